dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 512: number of 32-bit RAM words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_1000: byte address of RAM word 0.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1: processor presents a load or store request.
REQ-006 SHALL have port req_ready, output, 1: responder accepts a request this cycle.
REQ-007 SHALL have port req_wren, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3: RV32I access size and extension code.
REQ-009 SHALL have port req_address, input, 32: byte address.
REQ-010 SHALL have port req_data_in, input, 32: store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1: response available.
REQ-012 SHALL have port rsp_ready, input, 1: processor consumes the response.
REQ-013 SHALL have port rsp_data_out, output, 32: load result, extended to 32 bits.
REQ-014 SHALL have port rsp_error, output, 1: request was rejected with no side effect.

Function
REQ-015 SHALL implement states IDLE, ACCESS and RESPOND; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL move IDLE->ACCESS when req_valid & req_ready, latching wren, funct3, address and data.
REQ-017 SHALL always move ACCESS->RESPOND after one cycle; the RAM read is registered in ACCESS.
REQ-018 SHALL assert rsp_valid in RESPOND and hold rsp_valid, rsp_data_out and rsp_error stable until rsp_ready; RESPOND->IDLE on rsp_valid & rsp_ready.
REQ-019 SHALL give a fixed latency: acceptance at edge T, rsp_valid high from edge T+2; the earliest next acceptance is the cycle after the response handshake.
REQ-020 SHALL accept load funct3 000 lb, 001 lh, 010 lw, 100 lbu and 101 lhu; lb and lh SHALL sign-extend, lbu and lhu SHALL zero-extend.
REQ-021 SHALL accept store funct3 000 sb, 001 sh and 010 sw; sb and sh SHALL update only the addressed byte lanes, little-endian.
REQ-022 SHALL flag errors for any other funct3, for half accesses with addr[0]!=0, and for word accesses with addr[1:0]!=0.
REQ-023 SHALL flag an error when the address is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS-1]; the range arithmetic SHALL be 32-bit unsigned with no wrap-around acceptance.
REQ-024 SHALL, on error, write nothing, set rsp_error=1 and drive rsp_data_out=0.
REQ-025 SHALL commit a store to RAM on the edge leaving ACCESS; a store response SHALL carry rsp_data_out=0 and rsp_error=0.
REQ-026 SHALL make a load immediately after a store to the same address return the stored data.
REQ-027 SHALL ignore req_valid and the other req_* inputs in ACCESS and RESPOND.

Reset
REQ-028 SHALL, while reset_n=0, force state=IDLE, req_ready=0, rsp_valid=0, rsp_data_out=0 and rsp_error=0; req_ready SHALL rise in the first cycle after release.
REQ-029 SHALL NOT reset RAM contents.
REQ-030 SHALL, if reset is asserted in ACCESS before the commit edge, abort the store with no RAM write; a pending response SHALL be discarded.

Configuration
REQ-031 SHALL, when DMEM_RESPONDER_MMIO_EN is defined, include a free-running 32-bit cycle counter that is reset to 0, wraps 32'hFFFF_FFFF->0, and is read by lw at 32'hFFFF_FFF0.
REQ-032 SHALL, with DMEM_RESPONDER_MMIO_EN defined, return the counter value sampled at the ACCESS edge; any store or non-lw access to 32'hFFFF_FFF0 SHALL flag an error.
REQ-033 SHALL, without DMEM_RESPONDER_MMIO_EN, contain no counter logic and treat 32'hFFFF_FFF0 as out of range (error).

Verification
REQ-034 SHALL cover: sw 32'hDEADBEEF to 0x1000, then lw 0x1000 -> rsp_data_out=32'hDEADBEEF, rsp_error=0, rsp_valid 2 cycles after acceptance.
REQ-035 SHALL cover: with 0x1004=32'h0000_80F0, lb 0x1004 -> 32'hFFFF_FFF0; lbu -> 32'h0000_00F0; lh 0x1004 -> 32'hFFFF_80F0; lhu -> 32'h0000_80F0.
REQ-036 SHALL cover: sb 8'hAA to 0x1002 over word 32'h11223344 -> lw returns 32'h11AA3344.
REQ-037 SHALL cover: lw 0x1002, sh 0x1001, funct3=011, and lw 0x0FFC -> each gives rsp_error=1, rsp_data_out=0, and RAM is unchanged.
REQ-038 SHALL cover: hold rsp_ready=0 for 5 cycles -> rsp_valid and data stay stable and req_ready stays 0; then reset_n low during ACCESS of sw 0x1008 -> word unchanged.
REQ-039 SHALL cover, with DMEM_RESPONDER_MMIO_EN: two lw 0xFFFF_FFF0 accepted N cycles apart -> values differ by N; sw there -> rsp_error=1.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port RV32I data-memory responder: one request at a time, fixed two-cycle latency.
// Define DMEM_RESPONDER_MMIO_EN to add a free-running cycle counter readable by lw at 32'hFFFF_FFF0.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wren,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data_out,
  output logic        rsp_error
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t state, state_next;

  logic        wren_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rd_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             bad_op;
  logic             misaligned;
  logic             access_error;
  logic [31:0]      read_word;
  logic [3:0]       byte_en;
  logic [31:0]      wdata;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [31:0]      load_data;

  // Unsigned offset: addresses below BASE_ADDR are rejected by the explicit compare, not by wrap.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && (offset < SPAN_BYTES);
  assign idx      = offset[IDX_W+1:2];

  always_comb begin
    bad_op     = 1'b0;
    misaligned = 1'b0;
    case (funct3_q)
      3'b000: bad_op = 1'b0;
      3'b001: misaligned = addr_q[0];
      3'b010: misaligned = |addr_q[1:0];
      3'b100: bad_op = wren_q;
      3'b101: begin
        bad_op     = wren_q;
        misaligned = addr_q[0];
      end
      default: bad_op = 1'b1;
    endcase
  end

`ifdef DMEM_RESPONDER_MMIO_EN
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

  logic [31:0] cycle_count;
  logic        is_mmio;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycle_count <= '0;
    else          cycle_count <= cycle_count + 32'd1;
  end

  assign is_mmio      = (addr_q == MMIO_ADDR);
  assign access_error = is_mmio ? (wren_q || (funct3_q != 3'b010))
                                : (bad_op || misaligned || !in_range);
  assign read_word    = is_mmio ? cycle_count : mem[idx];
`else
  assign access_error = bad_op || misaligned || !in_range;
  assign read_word    = mem[idx];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reset_n;
        if (req_valid) state_next = ACCESS;
      end
      ACCESS: state_next = RESPOND;
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wren_q   <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else if (state == IDLE && req_valid) begin
      wren_q   <= req_wren;
      funct3_q <= req_funct3;
      addr_q   <= req_address;
      data_q   <= req_data_in;
    end
  end

  always_comb begin
    byte_en = 4'b0000;
    wdata   = data_q;
    case (funct3_q[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_q[1:0];
        wdata   = {4{data_q[7:0]}};
      end
      2'b01: begin
        byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{data_q[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase
  end

  // RAM has no reset; an async reset during ACCESS leaves IDLE before the commit edge.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      rd_q <= read_word;
      if (wren_q && !access_error) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    lane_byte = rd_q[8*addr_q[1:0] +: 8];
    lane_half = addr_q[1] ? rd_q[31:16] : rd_q[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'd0, lane_byte};
      3'b101:  load_data = {16'd0, lane_half};
      default: load_data = rd_q;
    endcase
  end

  assign rsp_data_out = (state == RESPOND && !wren_q && !access_error) ? load_data : 32'd0;
  assign rsp_error    = (state == RESPOND) && access_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; MMIO checks follow DMEM_RESPONDER_MMIO_EN.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wren = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_address = 32'd0;
  logic [31:0] req_data_in = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data_out;
  logic        rsp_error;

  int assert_count = 0;
  int fail_count   = 0;
  int cyc          = 0;

  dmem_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wren     (req_wren),
    .req_funct3   (req_funct3),
    .req_address  (req_address),
    .req_data_in  (req_data_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data_out (rsp_data_out),
    .rsp_error    (rsp_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Latency counts rising edges from the start of the handshake cycle to the first rsp_valid sample.
  task automatic applyStimulus(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic err, output int lat, output int acc_cyc);
    @(posedge clk); #1;
    req_valid   = 1'b1;
    req_wren    = wren;
    req_funct3  = f3;
    req_address = addr;
    req_data_in = wdata;
    acc_cyc     = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_data_out;
    err   = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic runCheck(input string tag, input logic wren, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_cyc;
    applyStimulus(wren, f3, addr, wdata, rdata, err, lat, acc_cyc);
    checkOutput({tag, "_data"}, rdata, exp_data);
    checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    checkOutput({tag, "_lat"}, lat, 32'd2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v1, v2;
    logic        e1, e2;
    int          l1, l2, c1, c2;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", rsp_data_out, 32'd0);
    checkOutput("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("post_rst_ready", {31'd0, req_ready}, 32'd1);

    runCheck("sw_1000", 1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, 32'h0, 1'b0);
    runCheck("lw_1000", 1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0);

    runCheck("sw_1004", 1'b1, 3'b010, 32'h1004, 32'h0000_80F0, 32'h0, 1'b0);
    runCheck("lb_1004", 1'b0, 3'b000, 32'h1004, 32'h0, 32'hFFFF_FFF0, 1'b0);
    runCheck("lbu_1004", 1'b0, 3'b100, 32'h1004, 32'h0, 32'h0000_00F0, 1'b0);
    runCheck("lh_1004", 1'b0, 3'b001, 32'h1004, 32'h0, 32'hFFFF_80F0, 1'b0);
    runCheck("lhu_1004", 1'b0, 3'b101, 32'h1004, 32'h0, 32'h0000_80F0, 1'b0);

    runCheck("sw_base", 1'b1, 3'b010, 32'h1000, 32'h1122_3344, 32'h0, 1'b0);
    runCheck("sb_1002", 1'b1, 3'b000, 32'h1002, 32'hFFFF_FFAA, 32'h0, 1'b0);
    runCheck("lw_after_sb", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h11AA_3344, 1'b0);
    runCheck("sh_1002", 1'b1, 3'b001, 32'h1002, 32'h0000_5566, 32'h0, 1'b0);
    runCheck("lw_after_sh", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h5566_3344, 1'b0);
    runCheck("lh_1002", 1'b0, 3'b001, 32'h1002, 32'h0, 32'h0000_5566, 1'b0);
    runCheck("lbu_1003", 1'b0, 3'b100, 32'h1003, 32'h0, 32'h0000_0055, 1'b0);
    runCheck("lb_1001", 1'b0, 3'b000, 32'h1001, 32'h0, 32'h0000_0033, 1'b0);

    runCheck("lw_misal", 1'b0, 3'b010, 32'h1002, 32'h0, 32'h0, 1'b1);
    runCheck("sh_misal", 1'b1, 3'b001, 32'h1001, 32'h0000_BEEF, 32'h0, 1'b1);
    runCheck("ld_f3_011", 1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 1'b1);
    runCheck("st_f3_011", 1'b1, 3'b011, 32'h1000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    runCheck("st_f3_100", 1'b1, 3'b100, 32'h1000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    runCheck("lw_below", 1'b0, 3'b010, 32'h0FFC, 32'h0, 32'h0, 1'b1);
    runCheck("sw_below", 1'b1, 3'b010, 32'h0FFC, 32'hFFFF_FFFF, 32'h0, 1'b1);
    runCheck("lw_unchanged", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h5566_3344, 1'b0);

    runCheck("sw_last", 1'b1, 3'b010, 32'h17FC, 32'hA5A5_5A5A, 32'h0, 1'b0);
    runCheck("lw_last", 1'b0, 3'b010, 32'h17FC, 32'h0, 32'hA5A5_5A5A, 1'b0);
    runCheck("lw_past_end", 1'b0, 3'b010, 32'h1800, 32'h0, 32'h0, 1'b1);
    runCheck("sb_past_end", 1'b1, 3'b000, 32'h1800, 32'h0, 32'h0, 1'b1);
    runCheck("lw_top", 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);

    // Backpressure: response must hold while stray requests are ignored.
    @(posedge clk); #1;
    req_valid = 1'b1; req_wren = 1'b0; req_funct3 = 3'b010; req_address = 32'h1004;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("bp_valid_first", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_wren = 1'b1; req_funct3 = 3'b010;
      req_address = 32'h1004; req_data_in = 32'h0BAD_0BAD;
      @(posedge clk); #1;
      checkOutput("bp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_data", rsp_data_out, 32'h0000_80F0);
      checkOutput("bp_error", {31'd0, rsp_error}, 32'd0);
      checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("bp_valid_done", {31'd0, rsp_valid}, 32'd0);
    checkOutput("bp_ready_back", {31'd0, req_ready}, 32'd1);
    runCheck("lw_after_bp", 1'b0, 3'b010, 32'h1004, 32'h0, 32'h0000_80F0, 1'b0);

    // Reset during ACCESS must abort the store.
    runCheck("sw_1008", 1'b1, 3'b010, 32'h1008, 32'hCAFE_F00D, 32'h0, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wren = 1'b1; req_funct3 = 3'b010;
    req_address = 32'h1008; req_data_in = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("ra_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("ra_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("ra_rsp_data", rsp_data_out, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    runCheck("lw_1008_kept", 1'b0, 3'b010, 32'h1008, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Reset during RESPOND discards the pending response.
    @(posedge clk); #1;
    req_valid = 1'b1; req_wren = 1'b0; req_funct3 = 3'b010; req_address = 32'h1000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rr_valid_before", {31'd0, rsp_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rr_valid_in_rst", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rr_valid_after", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rr_ready_after", {31'd0, req_ready}, 32'd1);

`ifdef DMEM_RESPONDER_MMIO_EN
    applyStimulus(1'b0, 3'b010, 32'hFFFF_FFF0, 32'h0, v1, e1, l1, c1);
    repeat (7) @(posedge clk);
    applyStimulus(1'b0, 3'b010, 32'hFFFF_FFF0, 32'h0, v2, e2, l2, c2);
    checkOutput("mmio_err1", {31'd0, e1}, 32'd0);
    checkOutput("mmio_err2", {31'd0, e2}, 32'd0);
    checkOutput("mmio_lat", l2, 32'd2);
    checkOutput("mmio_delta", v2 - v1, 32'(c2 - c1));
    runCheck("mmio_sw", 1'b1, 3'b010, 32'hFFFF_FFF0, 32'h1, 32'h0, 1'b1);
    runCheck("mmio_lh", 1'b0, 3'b001, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1);
`else
    v1 = 32'd0; v2 = 32'd0; e1 = 1'b0; e2 = 1'b0; l1 = 0; l2 = 0; c1 = 0; c2 = 0;
    runCheck("mmio_off_lw", 1'b0, 3'b010, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
